// File: rtl/vga_pkg.sv
// vga_pkg: object-table field offsets, video geometry and display-list types shared by the VGA overlay path
package vga_pkg;
    localparam int X_MSB = 31;
    localparam int Y_MSB = 21;
    localparam int OWNER_BIT = 3;
    localparam int ACTIVE_BIT = 2;
    localparam int VIDEO_WIDTH = 640;
    localparam int VIDEO_HEIGHT = 480;
    typedef struct packed {
        logic [9:0] x;
        logic owner;
        logic valid;
    } list_entry_t;
    localparam int LIST_ENTRY_W = $bits(list_entry_t);
    typedef enum logic {IDLE, SCAN} scan_state_t;
endpackage

// File: rtl/scanline_obj_scanner.sv
// scanline_obj_scanner: scans the object table once per line into a shadow display list
module scanline_obj_scanner
    import vga_pkg::*;
#(
    parameter int NUM_OBJS = 64,
    parameter int OBJ_SIZE = 12,
    parameter int MAX_PER_LINE = 8
) (
    input logic clk,
    input logic reset,
    input logic line_start,
    input logic [8:0] next_y,
    input logic [NUM_OBJS*32-1:0] obj_table,
    output list_entry_t commit [MAX_PER_LINE],
    output logic scan_busy,
    output logic line_ovf,
    output logic scan_abort
);
    localparam int IDX_W = $clog2(NUM_OBJS);
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    scan_state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic [8:0] tgt_y;
    list_entry_t shadow [MAX_PER_LINE];
    logic [31:0] ent;
    logic [9:0] ey;
    logic hit, full, store, last, unused_ent;
    assign ent = obj_table[32*idx +: 32];
    assign ey = {1'b0, ent[Y_MSB -: 9]};
    assign hit = state == SCAN && ent[ACTIVE_BIT] && {1'b0, tgt_y} >= ey && {1'b0, tgt_y} < ey + 10'(OBJ_SIZE);
    assign full = count == CNT_W'(MAX_PER_LINE);
    assign store = hit && !full;
    assign last = idx == IDX_W'(NUM_OBJS - 1);
    assign scan_busy = state == SCAN;
    assign unused_ent = ^{ent[Y_MSB-9:OWNER_BIT+1], ent[ACTIVE_BIT-1:0]};
    always_comb begin
        state_nx = state;
        if (line_start) state_nx = SCAN;
        else if (state == SCAN && last) state_nx = IDLE;
    end
    // the commit view folds in this cycle's entry so a coincident line_start keeps its hit
    always_comb
        for (int i = 0; i < MAX_PER_LINE; i++)
            commit[i] = (store && count == CNT_W'(i)) ? {ent[X_MSB -: 10], ent[OWNER_BIT], 1'b1} : shadow[i];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            count <= '0;
            tgt_y <= '0;
            line_ovf <= 1'b0;
            scan_abort <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) shadow[i] <= '0;
        end else begin
            state <= state_nx;
            line_ovf <= line_ovf | (hit && full);
            scan_abort <= scan_abort | (line_start && scan_busy);
            if (line_start) begin
                idx <= '0;
                count <= '0;
                tgt_y <= next_y;
                for (int i = 0; i < MAX_PER_LINE; i++) shadow[i] <= '0;
            end else if (scan_busy) begin
                idx <= last ? '0 : idx + 1'b1;
                count <= count + CNT_W'(store);
                for (int i = 0; i < MAX_PER_LINE; i++) shadow[i] <= commit[i];
            end
        end
    end
endmodule

// File: rtl/vga_scanline_compositor.sv
// vga_scanline_compositor: display-list object overlay with a 2-stage pixel compositing pipeline
module vga_scanline_compositor
    import vga_pkg::*;
#(
    parameter int NUM_OBJS = 64,
    parameter int OBJ_SIZE = 12,
    parameter int MAX_PER_LINE = 8,
    parameter int COLOR_BITS = 12,
    parameter logic [COLOR_BITS-1:0] P1_COLOR = 12'hF00,
    parameter logic [COLOR_BITS-1:0] P2_COLOR = 12'h00F
) (
    input logic clk,
    input logic reset,
    input logic line_start,
    input logic [8:0] next_y,
    input logic [NUM_OBJS*32-1:0] obj_table,
    input logic [9:0] x,
    input logic [8:0] y,
    input logic active,
    input logic [COLOR_BITS-1:0] bg_color,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic scan_busy,
    output logic line_ovf,
    output logic scan_abort
);
    list_entry_t commit [MAX_PER_LINE];
    list_entry_t display [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] hit1, owner1;
    logic [COLOR_BITS-1:0] bg1, color;
    logic act1, unused_y;
    assign unused_y = ^y;
    scanline_obj_scanner #(
        .NUM_OBJS(NUM_OBJS),
        .OBJ_SIZE(OBJ_SIZE),
        .MAX_PER_LINE(MAX_PER_LINE)
    ) u_scanner (
        .clk(clk),
        .reset(reset),
        .line_start(line_start),
        .next_y(next_y),
        .obj_table(obj_table),
        .commit(commit),
        .scan_busy(scan_busy),
        .line_ovf(line_ovf),
        .scan_abort(scan_abort)
    );
    // lowest slot index wins where objects overlap
    always_comb begin
        color = bg1;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--)
            if (hit1[i]) color = owner1[i] ? P2_COLOR : P1_COLOR;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_PER_LINE; i++) display[i] <= '0;
            hit1 <= '0;
            owner1 <= '0;
            bg1 <= '0;
            act1 <= 1'b0;
            pix_color <= '0;
        end else begin
            if (line_start)
                for (int i = 0; i < MAX_PER_LINE; i++) display[i] <= commit[i];
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                hit1[i] <= display[i].valid && {1'b0, x} >= {1'b0, display[i].x}
                           && {1'b0, x} < {1'b0, display[i].x} + 11'(OBJ_SIZE);
                owner1[i] <= display[i].owner;
            end
            bg1 <= bg_color;
            act1 <= active;
            pix_color <= act1 ? color : '0;
        end
    end
endmodule

// File: tb/tb_vga_scanline_compositor.sv
// tb_vga_scanline_compositor: scoreboard bench for the scanline object compositor
module tb_vga_scanline_compositor;
    localparam int N = 64;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line_start = 1'b0;
    logic active = 1'b0;
    logic [8:0] next_y = '0;
    logic [8:0] y = '0;
    logic [9:0] x = '0;
    logic [11:0] bg_color = '0;
    logic [11:0] pix_color;
    logic scan_busy, line_ovf, scan_abort;
    logic [N*32-1:0] obj_table;
    logic [31:0] objs [N];
    logic [11:0] exp_q [$];
    int x_q [$];
    int checks = 0;
    int errors = 0;
    int mdl_x [8];
    bit mdl_own [8];
    bit mdl_v [8];

    vga_scanline_compositor dut (
        .clk(clk),
        .reset(reset),
        .line_start(line_start),
        .next_y(next_y),
        .obj_table(obj_table),
        .x(x),
        .y(y),
        .active(active),
        .bg_color(bg_color),
        .pix_color(pix_color),
        .scan_busy(scan_busy),
        .line_ovf(line_ovf),
        .scan_abort(scan_abort)
    );

    always #5 clk = ~clk;
    always_comb for (int i = 0; i < N; i++) obj_table[i*32 +: 32] = objs[i];

    function automatic logic [31:0] mk(int ox, int oy, bit own);
        return {10'(ox), 9'(oy), 9'd0, own, 1'b1, 2'b00};
    endfunction

    function automatic void clear_objs();
        for (int i = 0; i < N; i++) objs[i] = '0;
    endfunction

    // reference: first 8 hits among entries 0..lim-1 for target line ty
    function automatic void model_scan(int ty, int lim);
        int n;
        int oy;
        n = 0;
        for (int i = 0; i < 8; i++) mdl_v[i] = 0;
        for (int i = 0; i < lim; i++) begin
            oy = int'(objs[i][21:13]);
            if (objs[i][2] && ty >= oy && ty < oy + 12 && n < 8) begin
                mdl_x[n] = int'(objs[i][31:22]);
                mdl_own[n] = objs[i][3];
                mdl_v[n] = 1;
                n++;
            end
        end
    endfunction

    function automatic logic [11:0] model_color(int px, logic [11:0] bg);
        for (int i = 0; i < 8; i++)
            if (mdl_v[i] && px >= mdl_x[i] && px < mdl_x[i] + 12) return mdl_own[i] ? 12'h00F : 12'hF00;
        return bg;
    endfunction

    task automatic cyc();
        logic [11:0] e;
        int px;
        exp_q.push_back(active ? model_color(int'(x), bg_color) : 12'h000);
        x_q.push_back(int'(x));
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            px = x_q.pop_front();
            checks++;
            if (pix_color !== e) begin
                errors++;
                $display("FAIL pix x=%0d got %h expected %h", px, pix_color, e);
            end
        end
    endtask

    task automatic px(int xv, bit act);
        x = 10'(xv);
        active = act;
        bg_color = 12'(xv) ^ 12'h3C3;
        cyc();
    endtask

    task automatic idle(int n);
        active = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic pulse(int ty);
        next_y = 9'(ty);
        line_start = 1'b1;
        active = 1'b0;
        cyc();
        line_start = 1'b0;
    endtask

    task automatic sweep(int a, int b);
        for (int i = a; i <= b; i++) px(i, 1'b1);
        idle(2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        active = 1'b0;
        while (scan_busy && n < 100) begin
            cyc();
            n++;
        end
        checks++;
        if (scan_busy) begin
            errors++;
            $display("FAIL wait_idle scan_busy still %b after %0d cycles", scan_busy, n);
        end
    endtask

    task automatic run_line(int ty);
        wait_idle();
        pulse(ty);
        idle(70);
        pulse(ty);
        model_scan(ty, N);
    endtask

    task automatic test_reset();
        clear_objs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (pix_color !== 12'h000) begin errors++; $display("FAIL reset pix_color got %h expected 000", pix_color); end
        if (scan_busy !== 1'b0) begin errors++; $display("FAIL reset scan_busy got %b expected 0", scan_busy); end
        if (line_ovf !== 1'b0) begin errors++; $display("FAIL reset line_ovf got %b expected 0", line_ovf); end
        if (scan_abort !== 1'b0) begin errors++; $display("FAIL reset scan_abort got %b expected 0", scan_abort); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mdl_v[i] = 0;
        sweep(0, 20);
    endtask

    task automatic test_single();
        clear_objs();
        objs[0] = mk(100, 50, 1'b0);
        run_line(55);
        sweep(97, 114);
    endtask

    task automatic test_boundary();
        run_line(62);
        sweep(98, 113);
        run_line(61);
        sweep(98, 113);
        run_line(50);
        sweep(98, 113);
    endtask

    task automatic test_reset_midscan();
        clear_objs();
        objs[0] = mk(100, 50, 1'b0);
        run_line(55);
        sweep(98, 113);
        wait_idle();
        pulse(55);
        idle(20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks += 3;
        if (scan_busy !== 1'b0) begin errors++; $display("FAIL midscan_reset scan_busy got %b expected 0", scan_busy); end
        if (pix_color !== 12'h000) begin errors++; $display("FAIL midscan_reset pix_color got %h expected 000", pix_color); end
        if (line_ovf !== 1'b0) begin errors++; $display("FAIL midscan_reset line_ovf got %b expected 0", line_ovf); end
        reset = 1'b0;
        exp_q.delete();
        x_q.delete();
        for (int i = 0; i < 8; i++) mdl_v[i] = 0;
        sweep(98, 113);
        pulse(55);
        sweep(98, 113);
    endtask

    task automatic test_overflow();
        clear_objs();
        for (int i = 0; i < 9; i++) objs[i] = mk(16 * i + 10, 100, i[0]);
        checks++;
        if (line_ovf !== 1'b0) begin errors++; $display("FAIL ovf_before got %b expected 0", line_ovf); end
        run_line(100);
        checks++;
        if (line_ovf !== 1'b1) begin errors++; $display("FAIL ovf_after got %b expected 1", line_ovf); end
        sweep(0, 160);
    endtask

    task automatic test_overlap();
        clear_objs();
        objs[3] = mk(200, 300, 1'b1);
        objs[7] = mk(205, 300, 1'b0);
        run_line(305);
        sweep(196, 220);
    endtask

    task automatic test_abort();
        int hi;
        clear_objs();
        objs[2] = mk(10, 200, 1'b0);
        objs[5] = mk(30, 200, 1'b1);
        objs[9] = mk(50, 200, 1'b0);
        objs[12] = mk(70, 200, 1'b1);
        objs[20] = mk(90, 200, 1'b0);
        wait_idle();
        checks++;
        if (scan_abort !== 1'b0) begin errors++; $display("FAIL abort_before got %b expected 0", scan_abort); end
        pulse(205);
        idle(10);
        pulse(205);
        checks++;
        if (scan_abort !== 1'b1) begin errors++; $display("FAIL abort_after got %b expected 1", scan_abort); end
        model_scan(205, 10);
        hi = 0;
        for (int i = 0; i < 110; i++) begin
            if (scan_busy) hi++;
            px(i, 1'b1);
        end
        idle(2);
        checks++;
        if (hi !== 64) begin errors++; $display("FAIL abort_busy_cycles got %0d expected 64", hi); end
    endtask

    task automatic test_back_to_back();
        clear_objs();
        objs[0] = mk(320, 400, 1'b0);
        objs[63] = mk(300, 400, 1'b1);
        wait_idle();
        pulse(402);
        idle(63);
        pulse(402);
        model_scan(402, N);
        sweep(295, 335);
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_reset_midscan();
        test_overflow();
        test_overlap();
        test_abort();
        test_back_to_back();
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
